// File: rtl/inst_mem_pkg.sv
// Shared types, constants and the fetch fault helper for the pipelined
// instruction memory.
package inst_mem_pkg;

  // Lifecycle after reset: zero the array, accept a program, then serve fetches.
  typedef enum logic [1:0] {
    S_CLEAR,
    S_LOAD,
    S_RUN
  } imem_state_t;

  // RV32I canonical NOP (addi x0, x0, 0), returned on faulted fetches.
  localparam logic [31:0] NOP_RV32I = 32'h00000013;

  // Width at which the fault check is evaluated; fetch addresses up to this
  // width are zero-extended, so the result equals the native-width check.
  localparam int unsigned IMEM_ADR_MAX = 64;

  // A fetch faults if it lies below the base, is not word aligned, or
  // indexes past the last stored word. The below-base test comes first so
  // the wrapped offset never matters.
  function automatic logic imem_fault(input logic [IMEM_ADR_MAX-1:0] adr,
                                      input logic [IMEM_ADR_MAX-1:0] base,
                                      input int unsigned            depth);
    logic [IMEM_ADR_MAX-1:0] off;
    off = adr - base;
    return (adr < base) || (off[1:0] != 2'b00) ||
           ((off >> 2) >= IMEM_ADR_MAX'(depth));
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, combinational read.
// No reset on the array; the owner zeroes it by sweeping the write port.
module imem_array #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Single write port shared by the clear sweep and the program loader.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_mem_pl.sv
// Pipelined instruction memory: clear sweep, program load port, and a
// 1-cycle registered fetch with valid/ready handshake and fault reporting.
// Optional build macro INST_MEM_PARITY_EN adds a per-word even-parity bit,
// parity-fault forcing and the sticky par_err output.
module inst_mem_pl
  import inst_mem_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       DEPTH    = 256,
  parameter int unsigned       ADR_IN   = 64,
  parameter logic [ADR_IN-1:0] BASE_ADR = '0,
  parameter logic [WIDTH-1:0]  NOP_INST = WIDTH'(NOP_RV32I)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              load_last,
  output logic              load_err,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADR_IN-1:0] req_adr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_inst,
  output logic              rsp_fault,
  output logic              busy
`ifdef INST_MEM_PARITY_EN
  , output logic            par_err
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INST_MEM_PARITY_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif

  imem_state_t      state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic [AW:0]      ld_idx_q, ld_idx_d;   // one extra bit so "full" (==DEPTH) is representable
  logic             load_err_q, load_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_fault_q, rsp_fault_d;
  logic [WIDTH-1:0] rsp_inst_q, rsp_inst_d;
  logic             par_err_q, par_err_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [MW-1:0]    mem_wdata;
  logic [AW-1:0]    mem_raddr;
  logic [MW-1:0]    mem_rdata;
  logic             range_fault;
  logic             par_bad;
  logic             req_fire;

  imem_array #(
    .DW    (MW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign range_fault = imem_fault(IMEM_ADR_MAX'(req_adr), IMEM_ADR_MAX'(BASE_ADR), DEPTH);
  assign mem_raddr   = AW'((req_adr - BASE_ADR) >> 2);
`ifdef INST_MEM_PARITY_EN
  // Stored word plus parity bit must XOR to zero; only meaningful in range.
  assign par_bad = ^mem_rdata;
  assign par_err = par_err_q;
`else
  assign par_bad = 1'b0;
`endif

  assign load_ready = (state_q == S_LOAD);
  assign busy       = (state_q != S_RUN);
  assign req_ready  = (state_q == S_RUN) && (!rsp_valid_q || rsp_ready);
  assign req_fire   = req_valid && req_ready;
  assign load_err   = load_err_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_inst   = rsp_inst_q;
  assign rsp_fault  = rsp_fault_q;

  // Sequencing FSM: clear sweep, loader writes, overflow flag.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    ld_idx_d   = ld_idx_q;
    load_err_d = load_err_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_idx_q;
    mem_wdata  = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        if (clr_idx_q == AW'(DEPTH - 1)) state_d = S_LOAD;
        else                             clr_idx_d = clr_idx_q + 1'b1;
      end
      S_LOAD: begin
        if (load_valid) begin
          if (ld_idx_q < (AW+1)'(DEPTH)) begin
            mem_we    = 1'b1;
            mem_waddr = ld_idx_q[AW-1:0];
`ifdef INST_MEM_PARITY_EN
            mem_wdata = {^load_data, load_data};
`else
            mem_wdata = load_data;
`endif
            ld_idx_d  = ld_idx_q + 1'b1;
          end else begin
            load_err_d = 1'b1;
          end
          if (load_last) state_d = S_RUN;
        end
      end
      S_RUN:   ;
      default: state_d = S_CLEAR;
    endcase
  end

  // Response register: capture on accept, drop valid once consumed, else hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    rsp_inst_d  = rsp_inst_q;
    par_err_d   = par_err_q;
    if (req_fire) begin
      rsp_valid_d = 1'b1;
      rsp_fault_d = range_fault || par_bad;
      rsp_inst_d  = (range_fault || par_bad) ? NOP_INST : mem_rdata[WIDTH-1:0];
      if (!range_fault && par_bad) par_err_d = 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State and response registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_CLEAR;
      clr_idx_q   <= '0;
      ld_idx_q    <= '0;
      load_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_inst_q  <= '0;
      par_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      ld_idx_q    <= ld_idx_d;
      load_err_q  <= load_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_inst_q  <= rsp_inst_d;
      par_err_q   <= par_err_d;
    end
  end

endmodule
